// File: rtl/bcd_display_scan_ctrl.sv
// bcd_display_scan_ctrl
// Time-multiplexes one shared BCD seven-segment decoder across NUM_DIGITS
// common-anode digits. A shadow register takes new BCD values at any time;
// they reach the display register only on a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot starts with a few dead
// cycles (all digits off) to suppress ghosting.
//
// Optional feature: define BCD_SCAN_LEADING_ZERO_BLANK_EN to keep leading-zero
// digits (k>0, with every digit from k upwards equal to 0) dark.
module bcd_display_scan_ctrl #(
  parameter int NUM_DIGITS  = 2,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    pending,
  output logic [3:0]              dec_x,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [BCD_W-1:0]   shadow_reg, shadow_next;
  logic [BCD_W-1:0]   display_reg, display_next;
  logic               pending_reg, pending_next;
  logic [3:0]         dec_x_reg, dec_x_next;
  logic [NUM_DIGITS-1:0] dig_en_n_reg, dig_en_n_next;
  logic               frame_done_reg, frame_done_next;

  // Per-digit view of the display value that will be active next cycle.
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] show;

  // Nibble extraction and per-digit visibility (invalid codes stay dark).
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = display_next[4*gi +: 4];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign show[gi] = (nib[gi] <= 4'd9);
      end else begin : g_upper
        assign show[gi] = (nib[gi] <= 4'd9) && (|display_next[BCD_W-1:4*gi]);
      end
`else
      assign show[gi] = (nib[gi] <= 4'd9);
`endif
    end
  endgenerate

  // Scan state register: FSM state, slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic: slot timing, dead-time phase and digit rotation.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    cnt_inc    = cnt_reg + CNT_W'(1);
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = HAS_DEAD ? DEAD : ON;
        end
        default: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            state_next = HAS_DEAD ? DEAD : ON;
          end else begin
            cnt_next   = cnt_inc;
            state_next = (cnt_inc < CNT_DEAD) ? DEAD : ON;
          end
        end
      endcase
    end
  end

  // Load path: frame_done_reg marks the current cycle as the frame boundary.
  always_comb begin
    shadow_next  = shadow_reg;
    display_next = display_reg;
    pending_next = pending_reg;
    if (load && frame_done_reg) begin
      // Boundary load goes straight to the display; nothing is left pending.
      display_next = bcd_in;
      pending_next = 1'b0;
    end else if (load) begin
      shadow_next  = bcd_in;
      pending_next = 1'b1;
    end else if (pending_reg && (frame_done_reg || state_reg == IDLE)) begin
      display_next = shadow_reg;
      pending_next = 1'b0;
    end
  end

  // Shadow/display double buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg  <= '0;
      display_reg <= '0;
      pending_reg <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      display_reg <= display_next;
      pending_reg <= pending_next;
    end
  end

  // Output decode from next state so registered outputs line up with the state.
  always_comb begin
    dig_en_n_next   = '1;
    dec_x_next      = 4'd0;
    frame_done_next = 1'b0;
    if (state_next != IDLE) begin
      dec_x_next = nib[idx_next];
      if (state_next == ON && show[idx_next]) begin
        dig_en_n_next[idx_next] = 1'b0;
      end
      frame_done_next = (idx_next == IDX_LAST) && (cnt_next == CNT_LAST);
    end
  end

  // Output registers: digit enables and decoder nibble switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_en_n_reg   <= '1;
      dec_x_reg      <= 4'd0;
      frame_done_reg <= 1'b0;
    end else begin
      dig_en_n_reg   <= dig_en_n_next;
      dec_x_reg      <= dec_x_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign pending    = pending_reg;
  assign dec_x      = dec_x_reg;
  assign dig_en_n   = dig_en_n_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Testbench for bcd_display_scan_ctrl (NUM_DIGITS=2, PRESCALE=8, DEAD_CYCLES=2).
// A reference model tracks time since scanning started and derives the slot,
// digit and dead-time phase arithmetically; directed table vectors, hand
// sequences and random stimulus are all compared each cycle.
module tb_bcd_display_scan_ctrl;
  localparam int N = 2;
  localparam int P = 8;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       load;
  logic [7:0] bcd_in;
  logic       pending;
  logic [3:0] dec_x;
  logic [1:0] dig_en_n;
  logic       frame_done;

  bcd_display_scan_ctrl #(
    .NUM_DIGITS (N),
    .PRESCALE   (P),
    .DEAD_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .bcd_in    (bcd_in),
    .pending   (pending),
    .dec_x     (dec_x),
    .dig_en_n  (dig_en_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_t = cycles since scanning began (-1 when idle).
  int         m_t;
  logic [7:0] m_disp;
  logic [7:0] m_shadow;
  bit         m_pend;

  function automatic logic [3:0] m_nib(int k);
    logic [7:0] v;
    v = m_disp >> (4 * k);
    return v[3:0];
  endfunction

  function automatic int m_digit();
    return (m_t / P) % N;
  endfunction

  function automatic int m_off();
    return m_t % P;
  endfunction

  function automatic logic [1:0] exp_dig();
    logic [1:0] r;
    int         k;
    bit         vis;
    r = 2'b11;
    if (m_t >= 0 && m_off() >= D) begin
      k   = m_digit();
      vis = (m_nib(k) <= 4'd9);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (k > 0 && (m_disp >> (4 * k)) == 8'd0) vis = 1'b0;
`endif
      if (vis) r = r & ~(2'b01 << k);
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_dec();
    return (m_t < 0) ? 4'd0 : m_nib(m_digit());
  endfunction

  function automatic bit exp_fd();
    return (m_t >= 0) && (m_digit() == N - 1) && (m_off() == P - 1);
  endfunction

  task automatic model_reset();
    m_t      = -1;
    m_disp   = 8'h00;
    m_shadow = 8'h00;
    m_pend   = 1'b0;
  endtask

  task automatic model_step(bit en, bit ld, logic [7:0] bcd);
    bit fd;
    fd = exp_fd();
    if (fd && ld) begin
      m_disp = bcd;
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = bcd;
      m_pend   = 1'b1;
    end else if (m_pend && (m_t < 0 || fd)) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (!en) m_t = -1;
    else     m_t = m_t + 1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic check_model();
    chk("m_dig_en_n", 8'(dig_en_n), 8'(exp_dig()));
    chk("m_dec_x", 8'(dec_x), 8'(exp_dec()));
    chk("m_frame_done", 8'(frame_done), 8'(exp_fd()));
    chk("m_pending", 8'(pending), 8'(m_pend));
  endtask

  task automatic tick(bit en, bit ld, logic [7:0] bcd);
    enable = en;
    load   = ld;
    bcd_in = bcd;
    @(posedge clk);
    model_step(en, ld, bcd);
    #1;
    check_model();
  endtask

  task automatic advance_to(int d, int o);
    int guard;
    guard = 0;
    while (!(m_t >= 0 && m_digit() == d && m_off() == o)) begin
      tick(1'b1, 1'b0, 8'h00);
      guard++;
      if (guard > 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL advance_to: slot %0d offset %0d not reached", d, o);
        break;
      end
    end
  endtask

  typedef struct {
    bit         en;
    bit         ld;
    logic [7:0] bcd;
    logic [1:0] dig;
    logic [3:0] dec;
    bit         fd;
    bit         pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit en, bit ld, logic [7:0] bcd, logic [1:0] dig,
                     logic [3:0] dec, bit fd, bit pend);
    vec_t v;
    v.en = en; v.ld = ld; v.bcd = bcd;
    v.dig = dig; v.dec = dec; v.fd = fd; v.pend = pend;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         r_en;
    bit         r_ld;
    logic [7:0] r_bcd;

    // Table for the basic scan of 8'h47: load in IDLE, transfer, two frames.
    add(1'b0, 1'b1, 8'h47, 2'b11, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 2'b11, 4'd0, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, 2'b11, 4'd7, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 8'h00, 2'b10, 4'd7, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, 2'b11, 4'd4, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'h00, 2'b01, 4'd4, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 2'b01, 4'd4, 1'b1, 1'b0);
    end
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 8'h00, 2'b11, 4'd7, 1'b0, 1'b0);

    // Reset values
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcd_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig_en_n", 8'(dig_en_n), 8'h03);
    chk("rst_dec_x", 8'(dec_x), 8'h00);
    chk("rst_frame_done", 8'(frame_done), 8'h00);
    chk("rst_pending", 8'(pending), 8'h00);
    rst_n = 1'b1;

    // Table-driven basic scan
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].en, vecs[i].ld, vecs[i].bcd);
      $display("vec %0d en=%0b ld=%0b bcd=%02h -> dig=%b dec=%0d fd=%0b pend=%0b",
               i, vecs[i].en, vecs[i].ld, vecs[i].bcd, dig_en_n, dec_x, frame_done, pending);
      chk("tbl_dig_en_n", 8'(dig_en_n), 8'(vecs[i].dig));
      chk("tbl_dec_x", 8'(dec_x), 8'(vecs[i].dec));
      chk("tbl_frame_done", 8'(frame_done), 8'(vecs[i].fd));
      chk("tbl_pending", 8'(pending), 8'(vecs[i].pend));
    end

    // Mid-frame load waits for the frame boundary
    advance_to(0, 3);
    tick(1'b1, 1'b1, 8'h12);
    $display("load 12 mid-frame: pend=%0b", pending);
    chk("mid_pend_set", 8'(pending), 8'h01);
    advance_to(1, 4);
    chk("mid_old_dec", 8'(dec_x), 8'h04);
    chk("mid_old_dig", 8'(dig_en_n), 8'h01);
    advance_to(1, 7);
    chk("mid_fd", 8'(frame_done), 8'h01);
    chk("mid_pend_hold", 8'(pending), 8'h01);
    tick(1'b1, 1'b0, 8'h00);
    chk("mid_pend_clr", 8'(pending), 8'h00);
    chk("mid_new_dec0", 8'(dec_x), 8'h02);
    advance_to(1, 2);
    chk("mid_new_dec1", 8'(dec_x), 8'h01);
    chk("mid_new_dig1", 8'(dig_en_n), 8'h01);

    // Two loads in one frame: last one wins
    advance_to(0, 3);
    tick(1'b1, 1'b1, 8'h33);
    $display("load 33 mid-frame");
    advance_to(1, 3);
    tick(1'b1, 1'b1, 8'h56);
    $display("load 56 mid-frame");
    advance_to(0, 2);
    chk("two_dec0", 8'(dec_x), 8'h06);
    chk("two_dig0", 8'(dig_en_n), 8'h02);
    advance_to(1, 2);
    chk("two_dec1", 8'(dec_x), 8'h05);

    // Load exactly in the frame_done cycle bypasses the shadow
    advance_to(1, 7);
    chk("byp_fd", 8'(frame_done), 8'h01);
    tick(1'b1, 1'b1, 8'h99);
    $display("load 99 at frame_done: pend=%0b dec=%0d", pending, dec_x);
    chk("byp_pend", 8'(pending), 8'h00);
    chk("byp_dec", 8'(dec_x), 8'h09);
    advance_to(0, 2);
    chk("byp_dig", 8'(dig_en_n), 8'h02);
    chk("byp_pend2", 8'(pending), 8'h00);

    // Invalid nibble stays dark but keeps its slot
    advance_to(0, 3);
    tick(1'b1, 1'b1, 8'h3A);
    $display("load 3A mid-frame");
    advance_to(0, 2);
    chk("inv_dig0", 8'(dig_en_n), 8'h03);
    chk("inv_dec0", 8'(dec_x), 8'h0A);
    advance_to(0, 6);
    chk("inv_dig0_late", 8'(dig_en_n), 8'h03);
    advance_to(1, 2);
    chk("inv_dig1", 8'(dig_en_n), 8'h01);
    chk("inv_dec1", 8'(dec_x), 8'h03);

    // Leading zero: display 05
    advance_to(0, 3);
    tick(1'b1, 1'b1, 8'h05);
    $display("load 05 mid-frame");
    advance_to(0, 2);
    chk("lz_dig0", 8'(dig_en_n), 8'h02);
    chk("lz_dec0", 8'(dec_x), 8'h05);
    advance_to(1, 2);
    chk("lz_dec1", 8'(dec_x), 8'h00);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    chk("lz_dig1", 8'(dig_en_n), 8'h03);
`else
    chk("lz_dig1", 8'(dig_en_n), 8'h01);
`endif

    // Enable dropped during slot 1 ON, then restart from slot 0 dead time
    advance_to(1, 4);
    tick(1'b0, 1'b0, 8'h00);
    $display("enable dropped: dig=%b", dig_en_n);
    chk("dis_dig", 8'(dig_en_n), 8'h03);
    chk("dis_dec", 8'(dec_x), 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("reen_dig_dead", 8'(dig_en_n), 8'h03);
    chk("reen_dec", 8'(dec_x), 8'h05);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("reen_dig_on", 8'(dig_en_n), 8'h02);

    // Asynchronous reset in the middle of an ON phase with data pending
    advance_to(0, 3);
    tick(1'b1, 1'b1, 8'h21);
    tick(1'b1, 1'b0, 8'h00);
    chk("ar_pend_before", 8'(pending), 8'h01);
    chk("ar_dig_before", 8'(dig_en_n), 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-ON: dig=%b pend=%0b", dig_en_n, pending);
    chk("ar_dig", 8'(dig_en_n), 8'h03);
    chk("ar_pend", 8'(pending), 8'h00);
    chk("ar_dec", 8'(dec_x), 8'h00);
    model_reset();
    enable = 1'b0; load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("ar_shadow_lost", 8'(dec_x), 8'h00);

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      r_en  = ($urandom_range(0, 49) != 0);
      r_ld  = ($urandom_range(0, 11) == 0);
      r_bcd = 8'($urandom);
      tick(r_en, r_ld, r_bcd);
      if (r_ld) $display("rand %0d load %02h en=%0b -> pend=%0b dec=%0d dig=%b",
                         i, r_bcd, r_en, pending, dec_x, dig_en_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
